// File: rtl/axi_ram_copy_ctrl.sv
// AXI4 master that copies len+1 beats from src_addr to dst_addr through one AXI RAM,
// moving the data in alternating read/write bursts of up to BUF_DEPTH beats.
module axi_ram_copy_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned BUF_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [7:0]            len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int unsigned IDX_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [7:0]  MAX_LEN = 8'(BUF_DEPTH - 1);
  localparam logic [8:0]  DEPTH9  = 9'(BUF_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] cur_src, cur_dst;
  logic [8:0]            remaining;
  logic [7:0]            burst_len;
  logic [7:0]            idx;
  logic [DATA_WIDTH-1:0] chunk_buf [BUF_DEPTH];

  logic                  ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [8:0]            chunk9, rem_left;
  logic [ADDR_WIDTH-1:0] step;

  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs  = m_axi_rvalid  & m_axi_rready;
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid  & m_axi_wready;
  assign b_hs  = m_axi_bvalid  & m_axi_bready;

  assign chunk9   = {1'b0, burst_len} + 9'd1;
  assign rem_left = remaining - chunk9;
  assign step     = ADDR_WIDTH'(chunk9) * ADDR_WIDTH'(STRB_WIDTH);

  assign m_axi_araddr = cur_src;
  assign m_axi_awaddr = cur_dst;
  assign m_axi_arlen  = burst_len;
  assign m_axi_awlen  = burst_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start)                state_n = RD_ADDR;
      RD_ADDR: if (ar_hs)                state_n = RD_DATA;
      RD_DATA: if (r_hs && m_axi_rlast)  state_n = WR_ADDR;
      WR_ADDR: if (aw_hs)                state_n = WR_DATA;
      WR_DATA: if (w_hs && m_axi_wlast)  state_n = WR_RESP;
      WR_RESP: if (b_hs)                 state_n = (rem_left == 9'd0) ? IDLE : RD_ADDR;
      default:                           state_n = IDLE;
    endcase
  end

  // Channel valids/readies are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      cur_src       <= '0;
      cur_dst       <= '0;
      remaining     <= 9'd0;
      burst_len     <= 8'd0;
      idx           <= 8'd0;
      m_axi_wdata   <= '0;
      m_axi_wlast   <= 1'b0;
    end else begin
      m_axi_arvalid <= (state_n == RD_ADDR);
      m_axi_rready  <= (state_n == RD_DATA);
      m_axi_awvalid <= (state_n == WR_ADDR);
      m_axi_wvalid  <= (state_n == WR_DATA);
      m_axi_bready  <= (state_n == WR_RESP);
      busy          <= (state_n != IDLE);
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_src   <= src_addr;
            cur_dst   <= dst_addr;
            remaining <= {1'b0, len} + 9'd1;
            burst_len <= (len >= MAX_LEN) ? MAX_LEN : len;
            idx       <= 8'd0;
            error     <= 1'b0;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            idx <= idx + 8'd1;
            if (m_axi_rresp != 2'b00) error <= 1'b1;
            if (m_axi_rlast) begin
              idx <= 8'd0;
              if (idx != burst_len) error <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (aw_hs) begin
            m_axi_wdata <= chunk_buf[0];
            m_axi_wlast <= (burst_len == 8'd0);
          end
        end
        WR_DATA: begin
          // Present the following beat only once the current one is taken.
          if (w_hs) begin
            if (m_axi_wlast) begin
              idx         <= 8'd0;
              m_axi_wlast <= 1'b0;
            end else begin
              idx         <= idx + 8'd1;
              m_axi_wdata <= chunk_buf[IDX_W'(idx + 8'd1)];
              m_axi_wlast <= ((idx + 8'd1) == burst_len);
            end
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            if (m_axi_bresp != 2'b00) error <= 1'b1;
            remaining <= rem_left;
            if (rem_left == 9'd0) begin
              done <= 1'b1;
            end else begin
              cur_src   <= cur_src + step;
              cur_dst   <= cur_dst + step;
              burst_len <= (rem_left >= DEPTH9) ? MAX_LEN : 8'(rem_left - 9'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Chunk buffer: plain storage, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (state == RD_DATA && r_hs) chunk_buf[IDX_W'(idx)] <= m_axi_rdata;
  end

endmodule

// File: tb/tb_axi_ram_copy_ctrl.sv
// Scoreboard bench for axi_ram_copy_ctrl: a behavioural AXI RAM slave plus an ordered
// queue of expected AR/AW/W/done events checked by an independent monitor.
module tb_axi_ram_copy_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [7:0]  len;
  logic        busy, done, error;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;

  axi_ram_copy_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .error(error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;   // 0 AR, 1 AW, 2 W, 3 done
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  ev_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          rbeat = 0;
  int          err_beat = -1;
  bit          stall_en = 1'b0;
  bit          init_tog = 1'b0;
  logic [31:0] mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_chunk(input logic [31:0] s, input logic [31:0] d, input int n);
    exp_q.push_back('{kind: 2'd0, a: s, b: 32'(n - 1)});
    exp_q.push_back('{kind: 2'd1, a: d, b: 32'(n - 1)});
    for (int i = 0; i < n; i++)
      exp_q.push_back('{kind: 2'd2, a: (s >> 2) + 32'(i), b: (i == n - 1) ? 32'd1 : 32'd0});
  endtask

  task automatic exp_done();
    exp_q.push_back('{kind: 2'd3, a: 32'd0, b: 32'd0});
  endtask

  // Behavioural RAM slave: handshakes seen at negedge take effect at the next posedge.
  initial begin
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, w_l, rd_active, b_pend, init_seen;
    logic [31:0] ar_a, aw_a, w_d, rd_addr, wr_addr;
    int rd_left;
    for (int k = 0; k < 256; k++) mem[k] = 32'(k);
    init_seen = 1'b0; rd_active = 1'b0; b_pend = 1'b0; rd_left = 0;
    rd_addr = 0; wr_addr = 0;
    m_axi_arready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready; ar_a = m_axi_araddr;
      r_hs  = m_axi_rvalid && m_axi_rready;
      aw_hs = m_axi_awvalid && m_axi_awready; aw_a = m_axi_awaddr;
      w_hs  = m_axi_wvalid && m_axi_wready; w_d = m_axi_wdata; w_l = m_axi_wlast;
      b_hs  = m_axi_bvalid && m_axi_bready;
      if (ar_hs) rd_left = int'(m_axi_arlen) + 1;
      @(posedge clk); #1;
      if (init_tog != init_seen) begin
        for (int k = 0; k < 256; k++) mem[k] = 32'(k);
        init_seen = init_tog;
      end
      if (rst) begin
        rd_active = 1'b0; b_pend = 1'b0;
        m_axi_arready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
        continue;
      end
      if (r_hs) begin
        rd_addr += 4; rd_left--; rbeat++;
        if (rd_left == 0) rd_active = 1'b0;
      end
      if (ar_hs) begin rd_active = 1'b1; rd_addr = ar_a; end
      if (b_hs) b_pend = 1'b0;
      if (aw_hs) wr_addr = aw_a;
      if (w_hs) begin
        mem[wr_addr[9:2]] = w_d;
        wr_addr += 4;
        if (w_l) b_pend = 1'b1;
      end
      m_axi_arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_active) begin
        if (!(m_axi_rvalid && !r_hs)) m_axi_rvalid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_rdata = mem[rd_addr[9:2]];
        m_axi_rlast = (rd_left == 1);
        m_axi_rresp = (rbeat == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
      end
      if (b_pend) begin
        if (!(m_axi_bvalid && !b_hs)) m_axi_bvalid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        m_axi_bvalid = 1'b0;
      end
    end
  end

  task automatic got(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] b,
                     input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk({nm, "_unexpected"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_kind"}, 32'(kind), 32'(e.kind));
      if (e.kind == kind && kind != 2'd3) begin
        chk({nm, "_addr_data"}, a, e.a);
        chk({nm, "_len_last"}, b, e.b);
      end
    end
  endtask

  // Monitor: pops one expected event per observed handshake or done pulse.
  initial begin
    bit          w_hold;
    logic [31:0] w_prev_d;
    logic        w_prev_l;
    w_hold = 1'b0; w_prev_d = '0; w_prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        w_hold = 1'b0;
        exp_q.delete();
      end else begin
        if (m_axi_arvalid && m_axi_arready) got(2'd0, m_axi_araddr, 32'(m_axi_arlen), "ar");
        if (m_axi_awvalid && m_axi_awready) got(2'd1, m_axi_awaddr, 32'(m_axi_awlen), "aw");
        if (w_hold && m_axi_wvalid) begin
          chk("wdata_stable", m_axi_wdata, w_prev_d);
          chk("wlast_stable", 32'(m_axi_wlast), 32'(w_prev_l));
        end
        if (m_axi_wvalid && m_axi_wready) got(2'd2, m_axi_wdata, 32'(m_axi_wlast), "w");
        if (done) begin
          done_cnt++;
          got(2'd3, 32'd0, 32'd0, "done");
        end
        w_hold = m_axi_wvalid && !m_axi_wready;
        w_prev_d = m_axi_wdata; w_prev_l = m_axi_wlast;
      end
    end
  end

  task automatic init_ram();
    init_tog = ~init_tog;
    repeat (2) @(posedge clk);
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [7:0] l);
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int want, input string nm);
    int n = 0;
    while (done_cnt < want && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_done_reached"}, 32'(done_cnt), 32'(want));
    repeat (5) @(posedge clk);
    chk({nm, "_done_once"}, 32'(done_cnt), 32'(want));
    chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    #3;
    chk("reset_ctrl", 32'({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid,
                           m_axi_bready, busy, done, error}), 32'd0);
    chk("reset_addr", m_axi_araddr | m_axi_awaddr, 32'd0);
    chk("reset_len_data", m_axi_wdata | 32'({m_axi_arlen, m_axi_awlen, 7'd0, m_axi_wlast}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single burst of 4 beats
    init_ram();
    exp_chunk(32'h00, 32'h40, 4); exp_done();
    start_copy(32'h0, 32'h40, 8'd3);
    wait_done(1, "t1");
    for (int i = 0; i < 4; i++) chk("t1_ram", mem[16 + i], 32'(i));
    chk("t1_error", 32'(error), 32'd0);

    // 2: 40 beats split 16/16/8
    init_ram();
    exp_chunk(32'h00, 32'h100, 16);
    exp_chunk(32'h40, 32'h140, 16);
    exp_chunk(32'h80, 32'h180, 8);
    exp_done();
    start_copy(32'h0, 32'h100, 8'd39);
    wait_done(2, "t2");
    for (int i = 0; i < 40; i++) chk("t2_ram", mem[64 + i], 32'(i));
    chk("t2_error", 32'(error), 32'd0);

    // 3: test 1 again with random stalls on every channel
    init_ram();
    stall_en = 1'b1;
    exp_chunk(32'h00, 32'h40, 4); exp_done();
    start_copy(32'h0, 32'h40, 8'd3);
    wait_done(3, "t3");
    stall_en = 1'b0;
    for (int i = 0; i < 4; i++) chk("t3_ram", mem[16 + i], 32'(i));
    chk("t3_error", 32'(error), 32'd0);

    // 4: extra start pulses while busy must be ignored
    init_ram();
    exp_chunk(32'h00, 32'h40, 8); exp_done();
    start_copy(32'h0, 32'h40, 8'd7);
    @(posedge clk); #1;
    chk("t4_busy_c2", 32'(busy), 32'd1);
    src_addr = 32'h300; dst_addr = 32'h380; len = 8'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("t4_busy_c10", 32'(busy), 32'd1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(4, "t4");
    for (int i = 0; i < 8; i++) chk("t4_ram", mem[16 + i], 32'(i));

    // 5: rresp error on beat 1; data still copied; next start clears error
    init_ram();
    base = rbeat;
    err_beat = base + 1;
    exp_chunk(32'h00, 32'h40, 4); exp_done();
    start_copy(32'h0, 32'h40, 8'd3);
    wait_done(5, "t5");
    err_beat = -1;
    chk("t5_error_set", 32'(error), 32'd1);
    for (int i = 0; i < 4; i++) chk("t5_ram", mem[16 + i], 32'(i));
    exp_chunk(32'h10, 32'h3F0, 1); exp_done();
    start_copy(32'h10, 32'h3F0, 8'd0);
    chk("t5_error_cleared", 32'(error), 32'd0);
    wait_done(6, "t5b");
    chk("t5b_ram", mem[252], 32'd4);
    chk("t5b_error", 32'(error), 32'd0);

    // 6: asynchronous reset in the middle of a write burst
    init_ram();
    exp_chunk(32'h00, 32'h80, 16); exp_done();
    start_copy(32'h0, 32'h80, 8'd15);
    n = 0;
    while (!m_axi_wvalid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_wr_data", 32'(m_axi_wvalid), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_reset", 32'({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid,
                               m_axi_bready, busy, done}), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("t6_no_done", 32'(done_cnt), 32'd6);
    init_ram();
    exp_chunk(32'h08, 32'h3C0, 1); exp_done();
    start_copy(32'h8, 32'h3C0, 8'd0);
    wait_done(7, "t6b");
    chk("t6b_ram", mem[240], 32'd2);
    chk("t6b_error", 32'(error), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
